keypad_matrix_scanner: RTL
==========================

// Module: keypad_matrix_scanner
// PURPOSE
// Parametrised successor to the fixed 4x4 keypad scan. Scans a ROWS x COLS active-low matrix with a
// programmable per-row settle time, synchronises and debounces whole scan frames, rejects multi-key
// (ghosting) frames and emits press/release events over a valid/ready interface to the game logic.
// Raw index codes only; any legend remapping is done downstream.
// PARAMETERS
// ROWS            4   number of driven row lines (>=2)
// COLS            4   number of sensed column lines (>=2)
// SETTLE_CYC      16  clk cycles each row is driven before its columns are sampled (>=3)
// DEBOUNCE_FRAMES 3   consecutive identical frames required to accept a new state (>=1)
// CODE_W          derived localparam = $clog2(ROWS*COLS), not overridable
// PORTS
// clk        in   1       system clock
// rst_n      in   1       asynchronous, active-low reset
// col        in   COLS    column sense lines, active-low, asynchronous to clk
// row        out  ROWS    row drive, active-low, exactly one bit low outside reset
// evt_valid  out  1       event available
// evt_ready  in   1       consumer accepts event when evt_valid&&evt_ready at posedge
// evt_code   out  CODE_W  key index = row_idx*COLS + col_idx
// evt_press  out  1       1 = press event, 0 = release event
// held       out  1       accepted state is a single key
// multi      out  1       accepted state is a multi-key frame
// BEHAVIOUR
// - Reset values: row=all 1s, evt_valid=0, evt_code=0, evt_press=0, held=0, multi=0; FIFO empty,
//   scan state row_idx=0, settle count=0, candidate=NONE, accepted=NONE, debounce count=0.
// - col passes through a 2-FF synchroniser before use.
// - Scan: row registered; row[row_idx]=0 from first cycle after reset. Settle counter runs 0..SETTLE_CYC-1;
//   at SETTLE_CYC-1 the synchronised col is sampled for row_idx, then row_idx advances (wraps ROWS-1 -> 0).
//   Frame = ROWS*SETTLE_CYC cycles; frame ends on the sample of row ROWS-1.
// - Frame classification: 0 low bits = NONE; exactly 1 = SINGLE(code); >=2 across whole frame = MULTI.
// - Debounce at frame end: if class/code == candidate, count++ (saturate at DEBOUNCE_FRAMES);
//   else candidate <= frame, count <= 1. Accept when count==DEBOUNCE_FRAMES and candidate != accepted.
// - Events on accept (pushed into 2-entry FIFO in order):
//   NONE->SINGLE(k): press k | SINGLE(k)->NONE: release k | SINGLE(k)->MULTI: release k
//   SINGLE(k)->SINGLE(j): release k, then press j | MULTI->SINGLE(j): press j | NONE<->MULTI: none
// - If FIFO free slots < events required, acceptance is deferred (accepted unchanged, nothing pushed);
//   retried at each later frame end. Events are never dropped or reordered.
// - held/multi reflect accepted state, updated in the cycle after acceptance.
// - Output: evt_valid = FIFO non-empty; evt_code/evt_press = FIFO head, stable while evt_valid&&!evt_ready.
//   Pop on evt_valid&&evt_ready. Push and pop in same cycle allowed, including when full (pop frees slot).
// - Latency: stable press -> evt_valid within (DEBOUNCE_FRAMES+1) frames + 3 cycles.
// - Async reset mid-frame or with events pending: all state returns to reset values; pending events lost.
// TESTING (ROWS=4, COLS=4, SETTLE_CYC=4, DEBOUNCE_FRAMES=3)
// 1 reset release -> row=1111 in reset, then 1110,1101,1011,0111 each 4 cycles, repeating; evt_valid=0.
// 2 hold key r2c1 5 frames, ready=1 -> one event press code 9, held=1; release -> one release code 9, held=0.
// 3 key r0c2 bouncing on/off per frame for 4 frames then stable -> no event until 3rd stable frame, then press 2.
// 4 hold r0c0 (accepted) then add r1c3 -> release 0 only, multi=1, held=0; drop r0c0 -> press 7.
// 5 ready=0, press r0c0, then roll to r3c3 -> head press 0 stable; ready=1 -> release 0, press 15 in order.
// 6 assert rst_n=0 mid-row with evt_valid=1 -> all outputs to reset values immediately; rescan from row 0.

Source files
------------

// File: rtl/keypad_matrix_scanner_if.sv
// ============================================================================
// Module   : keypad_matrix_scanner_if
// Brief    : Valid/ready key-event channel between the keypad scanner and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_matrix_scanner_if #(
    parameter int CODE_W = 4
) ();
    logic              evt_valid;
    logic              evt_ready;
    logic [CODE_W-1:0] evt_code;
    logic              evt_press;

    modport master (output evt_valid, evt_code, evt_press, input evt_ready);
    modport slave  (input evt_valid, evt_code, evt_press, output evt_ready);
endinterface

`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
// ============================================================================
// Module   : keypad_matrix_scanner
// Brief    : ROWS x COLS active-low keypad scan with frame debounce, ghost rejection
//            and press/release events queued in a 2-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_matrix_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYC      = 16,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire  [COLS-1:0]  col,
    output logic [ROWS-1:0]  row,
    output logic             held,
    output logic             multi,
    keypad_matrix_scanner_if.master evt
);

    localparam int CODE_W   = $clog2(ROWS * COLS);
    localparam int c_ridx_w = $clog2(ROWS);
    localparam int c_cidx_w = $clog2(COLS);
    localparam int c_set_w  = $clog2(SETTLE_CYC);
    localparam int c_db_w   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int c_ev_w   = CODE_W + 1;

    localparam logic [c_set_w-1:0]  c_settle_last = c_set_w'(SETTLE_CYC - 1);
    localparam logic [c_ridx_w-1:0] c_row_last    = c_ridx_w'(ROWS - 1);
    localparam logic [c_db_w-1:0]   c_db_full     = c_db_w'(DEBOUNCE_FRAMES);

    localparam logic [1:0] c_cls_none   = 2'd0;
    localparam logic [1:0] c_cls_single = 2'd1;
    localparam logic [1:0] c_cls_multi  = 2'd2;

    logic [COLS-1:0]     r_col_s1, r_col_s2;
    logic [ROWS-1:0]     r_row;
    logic [c_ridx_w-1:0] r_row_idx;
    logic [c_set_w-1:0]  r_settle;
    logic [1:0]          r_frm_hits;
    logic [CODE_W-1:0]   r_frm_code;
    logic [1:0]          r_cand_cls;
    logic [CODE_W-1:0]   r_cand_code;
    logic [c_db_w-1:0]   r_db_cnt;
    logic [1:0]          r_stable_cls;
    logic [CODE_W-1:0]   r_stable_code;
    logic                r_held, r_multi;
    logic [c_ev_w-1:0]   r_mem [0:1];
    logic                r_rd_ptr, r_wr_ptr;
    logic [1:0]          r_fifo_cnt;

    logic [c_ridx_w-1:0] w_row_idx_nxt;
    logic                w_sample, w_frame_end;
    logic [1:0]          w_row_hits;
    logic [c_cidx_w-1:0] w_row_col;
    logic [1:0]          w_hits_sum;
    logic [CODE_W-1:0]   w_code_here, w_code_sum;
    logic [1:0]          w_f_cls;
    logic [CODE_W-1:0]   w_f_code;
    logic                w_same, w_stable, w_changed;
    logic [c_db_w-1:0]   w_db_nxt;
    logic [1:0]          w_need, w_free;
    logic [c_ev_w-1:0]   w_ev0, w_ev1;
    logic                w_pop, w_accept;

    // ---------------- scan timing ----------------
    assign w_sample      = (r_settle == c_settle_last);
    assign w_frame_end   = w_sample && (r_row_idx == c_row_last);
    assign w_row_idx_nxt = !w_sample ? r_row_idx :
                           (r_row_idx == c_row_last) ? '0 : r_row_idx + 1'b1;

    // ---------------- per-row column decode ----------------
    always_comb begin
        w_row_hits = 2'd0;
        w_row_col  = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!r_col_s2[c]) begin
                if (w_row_hits != 2'd2) w_row_hits = w_row_hits + 2'd1;
                w_row_col = c_cidx_w'(c);
            end
        end
    end

    assign w_code_here = CODE_W'(r_row_idx) * CODE_W'(COLS) + CODE_W'(w_row_col);
    assign w_hits_sum  = (({1'b0, r_frm_hits} + {1'b0, w_row_hits}) >= 3'd2) ? 2'd2
                                                                           : r_frm_hits + w_row_hits;
    assign w_code_sum  = (r_frm_hits == 2'd0 && w_row_hits == 2'd1) ? w_code_here : r_frm_code;

    // Hit count saturates at 2, so it doubles as the frame class encoding.
    assign w_f_cls  = w_hits_sum;
    assign w_f_code = (w_hits_sum == c_cls_single) ? w_code_sum : '0;

    // ---------------- debounce ----------------
    assign w_same    = (w_f_cls == r_cand_cls) && (w_f_code == r_cand_code);
    assign w_db_nxt  = !w_same ? c_db_w'(1) :
                       (r_db_cnt == c_db_full) ? r_db_cnt : r_db_cnt + 1'b1;
    assign w_stable  = (w_db_nxt == c_db_full);
    assign w_changed = (w_f_cls != r_stable_cls) || (w_f_code != r_stable_code);

    // ---------------- event generation ----------------
    always_comb begin
        w_need = 2'd0;
        w_ev0  = '0;
        w_ev1  = '0;
        case (r_stable_cls)
            c_cls_none: begin
                if (w_f_cls == c_cls_single) begin
                    w_need = 2'd1;
                    w_ev0  = {1'b1, w_f_code};
                end
            end
            c_cls_single: begin
                w_ev0 = {1'b0, r_stable_code};
                if (w_f_cls == c_cls_single) begin
                    w_need = 2'd2;
                    w_ev1  = {1'b1, w_f_code};
                end else begin
                    w_need = 2'd1;
                end
            end
            c_cls_multi: begin
                if (w_f_cls == c_cls_single) begin
                    w_need = 2'd1;
                    w_ev0  = {1'b1, w_f_code};
                end
            end
            default: begin
                w_need = 2'd0;
            end
        endcase
    end

    // A pop in the same cycle frees its slot for this cycle's push.
    assign w_pop    = (r_fifo_cnt != 2'd0) && evt.evt_ready;
    assign w_free   = 2'd2 - r_fifo_cnt + {1'b0, w_pop};
    assign w_accept = w_frame_end && w_stable && w_changed && (w_free >= w_need);

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_s1      <= '1;
            r_col_s2      <= '1;
            r_row         <= '1;
            r_row_idx     <= '0;
            r_settle      <= '0;
            r_frm_hits    <= 2'd0;
            r_frm_code    <= '0;
            r_cand_cls    <= c_cls_none;
            r_cand_code   <= '0;
            r_db_cnt      <= '0;
            r_stable_cls  <= c_cls_none;
            r_stable_code <= '0;
            r_held        <= 1'b0;
            r_multi       <= 1'b0;
            r_mem[0]      <= '0;
            r_mem[1]      <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_fifo_cnt    <= 2'd0;
        end else begin
            r_col_s1  <= col;
            r_col_s2  <= r_col_s1;
            r_row     <= ~(ROWS'(1) << w_row_idx_nxt);
            r_row_idx <= w_row_idx_nxt;
            r_settle  <= w_sample ? '0 : r_settle + 1'b1;

            if (w_frame_end) begin
                r_frm_hits  <= 2'd0;
                r_frm_code  <= '0;
                r_cand_cls  <= w_f_cls;
                r_cand_code <= w_f_code;
                r_db_cnt    <= w_db_nxt;
            end else if (w_sample) begin
                r_frm_hits <= w_hits_sum;
                r_frm_code <= w_code_sum;
            end

            if (w_accept) begin
                r_stable_cls  <= w_f_cls;
                r_stable_code <= w_f_code;
                r_held        <= (w_f_cls == c_cls_single);
                r_multi       <= (w_f_cls == c_cls_multi);
                if (w_need != 2'd0) r_mem[r_wr_ptr]  <= w_ev0;
                if (w_need == 2'd2) r_mem[~r_wr_ptr] <= w_ev1;
                r_wr_ptr <= r_wr_ptr ^ w_need[0];
            end

            r_rd_ptr   <= r_rd_ptr ^ w_pop;
            r_fifo_cnt <= r_fifo_cnt - {1'b0, w_pop} + (w_accept ? w_need : 2'd0);
        end
    end

    assign row           = r_row;
    assign held          = r_held;
    assign multi         = r_multi;
    assign evt.evt_valid = (r_fifo_cnt != 2'd0);
    assign evt.evt_code  = r_mem[r_rd_ptr][CODE_W-1:0];
    assign evt.evt_press = r_mem[r_rd_ptr][CODE_W];

endmodule

`default_nettype wire
